// File: rtl/bnn_pkg.sv
// Shared definitions for the BNN nibble weight-load streamer.
//   NUM_NEURONS : weight words per image (default image length)
//   NIBBLE_W    : width of one beat on the target's nibble bus
//   WORD_W      : width of one neuron weight word
//   stream_state_e : streamer FSM encoding, also exported on dbg_state
package bnn_pkg;
  localparam int NUM_NEURONS = 16;
  localparam int NIBBLE_W    = 4;
  localparam int WORD_W      = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_LO    = 3'd2,
    ST_HI    = 3'd3,
    ST_DONE  = 3'd4
  } stream_state_e;
endpackage

// File: rtl/bnn_weight_streamer_if.sv
// Weight-word input stream.
//   s_valid : producer has a word on s_data
//   s_ready : consumer can take a word
//   s_data  : 8-bit weight word, bit i = weight of input i
// Handshake: a word transfers on every rising clk edge where s_valid and
// s_ready are both high. The producer must hold s_valid/s_data stable until
// that edge; s_ready may change freely and never depends on s_valid.
// Modports: master = producer (host), slave = streamer.
interface bnn_weight_streamer_if;
  logic                       s_valid;
  logic                       s_ready;
  logic [bnn_pkg::WORD_W-1:0] s_data;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/bnn_word_fifo.sv
// Synchronous word FIFO with asynchronous active-high reset and a
// synchronous flush that empties it regardless of push/pop.
//   clk, reset      : clock, async reset
//   flush           : drop all contents on this edge (wins over push/pop)
//   push, wr_data   : write a word (caller guarantees not full)
//   pop, rd_data    : consume head word; rd_data shows head while not empty
//   empty, full     : registered occupancy flags
//   count_next      : occupancy after this edge, lets the owner register a
//                     ready flag that is exact on the following cycle
module bnn_word_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             wr_data,
  input  logic                     pop,
  output logic [W-1:0]             rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count_next
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  mem_q [DEPTH];

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data    = mem_q[rd_ptr_q];
  assign empty      = (count_q == '0);
  assign full       = (count_q == CW'(DEPTH));
  assign count_next = count_d;
endmodule

// File: rtl/bnn_weight_streamer.sv
// Host-side transmitter for the BNN nibble weight-load interface.
// Buffers 8-bit weight words and sends each as two nibbles (low first) with
// load_en high for exactly the two tgt_ena-qualified beats of one neuron.
//   clk, reset : clock, async active-high reset
//   start      : 1-cycle pulse, begin a new image (aborts any transfer)
//   s_if       : weight word stream (slave side)
//   tgt_ena    : target's enable; beats advance only while high
//   load_en    : target uio[3]
//   nibble     : target uio[7:4]
//   tgt_rst    : 1-cycle pulse realigning the target's load pointer
//   busy       : in ARMED/LO/HI
//   done       : image complete (DONE)
//   word_cnt   : neurons fully transmitted this image
//   err        : sticky, word offered while DONE; cleared by start
//   dbg_state  : current FSM state
// All outputs are registered.
module bnn_weight_streamer #(
  parameter int NUM_NEURONS = bnn_pkg::NUM_NEURONS,
  parameter int FIFO_DEPTH  = 4,
  parameter int CNT_W       = 5
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  bnn_weight_streamer_if.slave          s_if,
  input  logic                          tgt_ena,
  output logic                          load_en,
  output logic [bnn_pkg::NIBBLE_W-1:0]  nibble,
  output logic                          tgt_rst,
  output logic                          busy,
  output logic                          done,
  output logic [CNT_W-1:0]              word_cnt,
  output logic                          err,
  output bnn_pkg::stream_state_e        dbg_state
);
  import bnn_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  stream_state_e       state_q, state_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [NIBBLE_W-1:0] nibble_q, nibble_d;
  logic                load_en_q, load_en_d;
  logic                tgt_rst_q, tgt_rst_d;
  logic [CNT_W-1:0]    word_cnt_q, word_cnt_d;
  logic                err_q, err_d;
  logic                s_ready_q, s_ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [WORD_W-1:0]   fifo_rd_data;
  logic [CW-1:0]       fifo_count_next;
  logic [CNT_W-1:0]    cnt_inc;
  logic                last_word;

  // A word offered on the start edge is discarded: start flushes the FIFO.
  assign fifo_push = s_if.s_valid & s_ready_q & ~start;
  assign cnt_inc   = word_cnt_q + 1'b1;
  assign last_word = (cnt_inc == CNT_W'(NUM_NEURONS));

  bnn_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (WORD_W)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (start),
    .push       (fifo_push),
    .wr_data    (s_if.s_data),
    .pop        (fifo_pop),
    .rd_data    (fifo_rd_data),
    .empty      (fifo_empty),
    .full       (fifo_full),
    .count_next (fifo_count_next)
  );

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = ST_ARMED;
    end else begin
      case (state_q)
        ST_ARMED: if (!fifo_empty && tgt_ena) state_d = ST_LO;
        ST_LO:    if (tgt_ena) state_d = ST_HI;
        ST_HI: begin
          if (tgt_ena) begin
            if (last_word)        state_d = ST_DONE;
            else if (!fifo_empty) state_d = ST_LO;
            else                  state_d = ST_ARMED;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  // FSM: outputs and datapath
  always_comb begin
    fifo_pop   = 1'b0;
    word_d     = word_q;
    nibble_d   = nibble_q;
    load_en_d  = load_en_q;
    tgt_rst_d  = 1'b0;
    word_cnt_d = word_cnt_q;
    err_d      = err_q;
    if (start) begin
      word_cnt_d = '0;
      err_d      = 1'b0;
      load_en_d  = 1'b0;
      nibble_d   = '0;
      tgt_rst_d  = 1'b1;
    end else begin
      case (state_q)
        ST_ARMED: begin
          if (!fifo_empty && tgt_ena) begin
            fifo_pop  = 1'b1;
            word_d    = fifo_rd_data;
            nibble_d  = fifo_rd_data[NIBBLE_W-1:0];
            load_en_d = 1'b1;
          end else begin
            load_en_d = 1'b0;
          end
        end
        ST_LO: begin
          if (tgt_ena) nibble_d = word_q[WORD_W-1:NIBBLE_W];
        end
        ST_HI: begin
          if (tgt_ena) begin
            word_cnt_d = cnt_inc;
            if (last_word) begin
              load_en_d = 1'b0;
              nibble_d  = '0;
            end else if (!fifo_empty) begin
              // Back-to-back neuron: load_en stays high across the boundary.
              fifo_pop  = 1'b1;
              word_d    = fifo_rd_data;
              nibble_d  = fifo_rd_data[NIBBLE_W-1:0];
              load_en_d = 1'b1;
            end else begin
              load_en_d = 1'b0;
            end
          end
        end
        ST_DONE: begin
          if (s_if.s_valid) err_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Status flags follow the next state so they are registered yet current.
  always_comb begin
    busy_d    = (state_d == ST_ARMED) || (state_d == ST_LO) || (state_d == ST_HI);
    done_d    = (state_d == ST_DONE);
    s_ready_d = busy_d && (fifo_count_next != CW'(FIFO_DEPTH));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_q     <= '0;
      nibble_q   <= '0;
      load_en_q  <= 1'b0;
      tgt_rst_q  <= 1'b0;
      word_cnt_q <= '0;
      err_q      <= 1'b0;
      s_ready_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      word_q     <= word_d;
      nibble_q   <= nibble_d;
      load_en_q  <= load_en_d;
      tgt_rst_q  <= tgt_rst_d;
      word_cnt_q <= word_cnt_d;
      err_q      <= err_d;
      s_ready_q  <= s_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign s_if.s_ready = s_ready_q;
  assign load_en      = load_en_q;
  assign nibble       = nibble_q;
  assign tgt_rst      = tgt_rst_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign word_cnt     = word_cnt_q;
  assign err          = err_q;
  assign dbg_state    = state_q;
endmodule

// File: doc/bnn_weight_streamer.md
Name: bnn_weight_streamer

Overview:
Host-side transmitter for the BNN nibble weight-load interface. It accepts 8-bit neuron weight words over a valid/ready stream and buffers them in a small FIFO. Each word is serialised as two 4-bit nibbles, low nibble first, with load_en held high for exactly the two beats the BNN needs to capture one neuron. It counts neurons, optionally realigns the target's load pointer at image start, and reports completion and protocol errors.

Parameters:
NUM_NEURONS, 16, weight words per image; done asserts after this many.
FIFO_DEPTH, 4, input word buffer depth (power of 2, >=2).
CNT_W, 5, width of word_cnt; must hold NUM_NEURONS.

Ports:
clk  in  1  clock
reset  in  1  async active-high reset
start  in  1  1-cycle pulse: begin new image (aborts any transfer in progress)
s_valid  in  1  input weight word valid
s_ready  out  1  word accepted on edge where s_valid&s_ready
s_data  in  8  weight word; bit i = weight of input i
tgt_ena  in  1  copy of target's ena; beats advance only when high
load_en  out  1  drives target uio[3]
nibble  out  4  drives target uio[7:4]
tgt_rst  out  1  1-cycle realign pulse to target load pointer
busy  out  1  high in ARMED/LO/HI
done  out  1  high in DONE
word_cnt  out  CNT_W  neurons fully transmitted this image
err  out  1  sticky: s_valid seen while DONE; cleared by start

Behaviour:
- Decided: reset is asynchronous and active-high; clock is clk. All outputs are registered.
- Reset values: state=IDLE, FIFO empty, load_en=0, nibble=0, tgt_rst=0, word_cnt=0, err=0, s_ready=0.
- States: IDLE, ARMED, LO, HI, DONE.
- s_ready = (state in ARMED/LO/HI) & FIFO not full. There is no input bypass.
- start, any state: flush FIFO, word_cnt<=0, err<=0, load_en<=0, nibble<=0, tgt_rst<=1 for the next cycle only, state<=ARMED.
- start has priority over every other same-edge event; a word offered on the start edge is discarded.
- ARMED: if FIFO non-empty & tgt_ena, pop the word, nibble<=word[3:0], load_en<=1, state<=LO. Otherwise load_en=0.
- LO (low nibble on pins): on an edge with tgt_ena=1, nibble<=held word[7:4], state<=HI. With tgt_ena=0, hold everything; the target also stalls.
- HI (high nibble on pins): on an edge with tgt_ena=1, word_cnt++.
  - If the new count == NUM_NEURONS: load_en<=0, nibble<=0, state<=DONE.
  - Else if FIFO non-empty: pop and present the next low nibble back-to-back, state<=LO, load_en stays 1.
  - Else: load_en<=0, state<=ARMED.
  - With tgt_ena=0: hold.
- load_en is never high for an odd number of tgt_ena-qualified beats outside an abort by start.
- Latency: word accepted at edge t with an idle pipe gives load_en=1 after edge t+1. Steady-state throughput is one word per 2 tgt_ena cycles.
- DONE: s_ready=0. s_valid=1 in any DONE cycle sets err. Leave DONE only via start or reset.
- IDLE: s_ready=0, s_valid ignored, err not set.
- FIFO full: s_ready=0. Push and pop on the same edge are legal when not full. Pointers wrap mod FIFO_DEPTH.
- Reset mid-pair: outputs drop to 0 immediately (async). The target must also be reset or restarted via start/tgt_rst.

Decomposition:
- Package bnn_pkg holds NUM_NEURONS, NIBBLE_W=4, WORD_W=8, and the streamer state enum.
- Sub-module bnn_word_fifo: synchronous FIFO with async reset, full/empty flags, and a flush input.

Test Plan:
- reset, start, push 0x3C -> load_en=1 with nibble=0xC then 0x3 on consecutive cycles; word_cnt=1; state back to ARMED.
- start, push 16 words 0x00..0x0F back-to-back, tgt_ena=1 -> 32 contiguous load_en beats; done=1 after the 32nd; word_cnt=16.
- Push 0xA5, drop tgt_ena for 3 cycles during the LO beat -> nibble holds 0x5 for the full stall, then 0xA; no extra beats.
- With the FIFO filled to 4 and the output stalled -> s_ready=0; the 5th word is not accepted and is sent later only once accepted.
- After done, assert s_valid -> err=1, s_ready=0. Then start -> err=0, tgt_rst=1 for one cycle, word_cnt=0.
- start mid-HI beat -> load_en=0 next cycle, FIFO flushed, word_cnt=0; the next pushed word restarts with its low nibble.
